// File: rtl/alu8_top_if.sv
// Handshake and data bundle between an ALU controller (master) and alu8_top (slave).
interface alu8_top_if;
  logic        start_i;
  logic [1:0]  opcode_i;
  logic [7:0]  operandA_i;
  logic [7:0]  operandB_i;
  logic [15:0] result_o;
  logic        done_o;

  modport master (
    output start_i, opcode_i, operandA_i, operandB_i,
    input  result_o, done_o
  );

  modport slave (
    input  start_i, opcode_i, operandA_i, operandB_i,
    output result_o, done_o
  );
endinterface

// File: rtl/alu8_top.sv
// 8-bit multi-cycle ALU: single-cycle ADD/SUB, 8-iteration shift-add MUL and
// restoring DIV, with a start/done handshake and a registered 16-bit result.
module alu8_top (
  input  logic       clk,
  input  logic       rst,
  alu8_top_if.slave  bus
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic        done_q, done_d;
  logic [8:0]  remTmp;
  logic [8:0]  remDiff;

  // MUL: a_q is the left-shifting multiplicand, b_q the right-shifting multiplier.
  // DIV: a_q[7:0] shifts dividend bits out and quotient bits in; acc_q[7:0] is the remainder.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    remTmp   = {acc_q[7:0], a_q[7]};
    remDiff  = remTmp - {1'b0, b_q};

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          op_d  = bus.opcode_i;
          a_d   = {8'h00, bus.operandA_i};
          b_d   = bus.operandB_i;
          cnt_d = 4'd8;
          case (bus.opcode_i)
            OP_ADD: begin
              acc_d   = {8'h00, bus.operandA_i} + {8'h00, bus.operandB_i};
              state_d = ST_DONE;
            end
            OP_SUB: begin
              acc_d   = {8'h00, bus.operandA_i} - {8'h00, bus.operandB_i};
              state_d = ST_DONE;
            end
            OP_MUL: begin
              acc_d   = 16'h0000;
              state_d = ST_MUL;
            end
            default: begin
              acc_d   = 16'h0000;
              state_d = ST_DIV;
            end
          endcase
        end
      end

      ST_MUL: begin
        if (b_q[0]) begin
          acc_d = acc_q + a_q;
        end
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_DONE;
        end
      end

      ST_DIV: begin
        a_d = {8'h00, a_q[6:0], 1'b0};
        if (remTmp >= {1'b0, b_q}) begin
          acc_d  = {8'h00, remDiff[7:0]};
          a_d[0] = 1'b1;
        end else begin
          acc_d  = {8'h00, remTmp[7:0]};
        end
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_DONE;
        end
      end

      default: begin
        result_d = (op_q == OP_DIV) ? {acc_q[7:0], a_q[7:0]} : acc_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= 16'h0000;
      b_q      <= 8'h00;
      acc_q    <= 16'h0000;
      cnt_q    <= 4'd0;
      result_q <= 16'h0000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.done_o   = done_q;

endmodule

// File: tb/tb_alu8_top.sv
// Scoreboard bench for alu8_top: expected result and latency are queued at launch
// and checked when done rises.
module tb_alu8_top;

  typedef struct {
    string       tag;
    logic [15:0] res;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sbQ[$];

  alu8_top_if bus ();

  alu8_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    case (op)
      2'b00:   r = 16'(a) + 16'(b);
      2'b01:   r = 16'(a) - 16'(b);
      2'b10:   r = 16'(a) * 16'(b);
      default: r = (b == 8'h00) ? {a, 8'hFF} : {a % b, a / b};
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one launch (called #1 after a rising edge) and returns #1 after the launch edge.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [7:0] a,
                               input logic [7:0] b, input bit hold, input bit scramble);
    exp_t e;
    bus.start_i    = 1'b1;
    bus.opcode_i   = op;
    bus.operandA_i = a;
    bus.operandB_i = b;
    e.tag = tag;
    e.res = model(op, a, b);
    e.lat = (op[1]) ? 9 : 1;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) bus.start_i = 1'b0;
    if (scramble) begin
      bus.opcode_i   = 2'($urandom);
      bus.operandA_i = 8'($urandom);
      bus.operandB_i = 8'($urandom);
    end
  endtask

  task automatic waitDone();
    int   lat;
    bit   seen;
    exp_t e;
    lat  = 0;
    seen = 1'b0;
    while (lat < 20 && !seen) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done_o) seen = 1'b1;
    end
    bus.start_i = 1'b0;
    if (sbQ.size() == 0) begin
      checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd1);
    end else begin
      e = sbQ.pop_front();
      checkOutput({e.tag, ".latency"}, 32'(lat), 32'(e.lat));
      checkOutput({e.tag, ".result"}, 32'(bus.result_o), 32'(e.res));
      @(posedge clk);
      #1;
      checkOutput({e.tag, ".doneWidth"}, 32'(bus.done_o), 32'd0);
      checkOutput({e.tag, ".resultHold"}, 32'(bus.result_o), 32'(e.res));
    end
  endtask

  task automatic countIdleDones(input string tag, input int cycles, input logic [15:0] holdRes);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) pulses++;
    end
    checkOutput({tag, ".noDone"}, 32'(pulses), 32'd0);
    checkOutput({tag, ".resultHeld"}, 32'(bus.result_o), 32'(holdRes));
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.opcode_i   = 2'b00;
    bus.operandA_i = 8'h00;
    bus.operandB_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.result", 32'(bus.result_o), 32'h0);
    checkOutput("reset.done", 32'(bus.done_o), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus("add15p10", 2'b00, 8'd15, 8'd10, 1'b0, 1'b0);   waitDone();
    applyStimulus("add255p255", 2'b00, 8'd255, 8'd255, 1'b0, 1'b0); waitDone();
    applyStimulus("sub20m5", 2'b01, 8'd20, 8'd5, 1'b0, 1'b0);     waitDone();
    applyStimulus("sub5m20", 2'b01, 8'd5, 8'd20, 1'b0, 1'b0);     waitDone();
    applyStimulus("mul7x3", 2'b10, 8'd7, 8'd3, 1'b0, 1'b0);       waitDone();
    applyStimulus("mul255x255", 2'b10, 8'd255, 8'd255, 1'b0, 1'b1); waitDone();
    applyStimulus("div40d5", 2'b11, 8'd40, 8'd5, 1'b0, 1'b0);     waitDone();
    applyStimulus("div43d5", 2'b11, 8'd43, 8'd5, 1'b0, 1'b1);     waitDone();
    applyStimulus("div9d0", 2'b11, 8'd9, 8'd0, 1'b0, 1'b0);       waitDone();

    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("rand%0d", i), 2'(i), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
      waitDone();
    end

    // start held high through MUL and its DONE state must yield exactly one pulse
    applyStimulus("mulHeld13x11", 2'b10, 8'd13, 8'd11, 1'b1, 1'b0);
    waitDone();
    countIdleDones("heldStart", 12, 16'd143);

    applyStimulus("add15p10b", 2'b00, 8'd15, 8'd10, 1'b0, 1'b0);  waitDone();
    applyStimulus("mulAbort", 2'b10, 8'd7, 8'd3, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort.result", 32'(bus.result_o), 32'h0);
    checkOutput("abort.done", 32'(bus.done_o), 32'h0);
    sbQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    countIdleDones("afterAbort", 15, 16'h0000);

    applyStimulus("mulAfterAbort", 2'b10, 8'd7, 8'd3, 1'b0, 1'b0); waitDone();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
